// File: rtl/simframe_sched.sv
// Frame scheduler: issues patterns from a writable table to the simulated-frame
// generator, one per frame, paced by a minimum period and bounded by a frame count.
module simframe_sched #(
  parameter int PATTERN_WIDTH = 32,
  parameter int TABLE_DEPTH   = 16,
  parameter int TABLE_AW      = $clog2(TABLE_DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cfg_we,
  input  logic [TABLE_AW-1:0]      i_cfg_addr,
  input  logic [PATTERN_WIDTH-1:0] i_cfg_data,
  input  logic [TABLE_AW:0]        i_pattern_count,
  input  logic [31:0]              i_frame_count,
  input  logic [31:0]              i_frame_period,
  input  logic                     i_start,
  input  logic                     i_stop,
  output logic [PATTERN_WIDTH-1:0] o_axis_out_tdata,
  output logic                     o_axis_out_tvalid,
  input  logic                     i_axis_out_tready,
  output logic                     o_busy,
  output logic [31:0]              o_frames_sent,
  output logic                     o_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  localparam logic [TABLE_AW:0]   LP_DEPTH   = (TABLE_AW+1)'(TABLE_DEPTH);
  localparam logic [TABLE_AW:0]   LP_PC_ONE  = (TABLE_AW+1)'(1);
  localparam logic [TABLE_AW-1:0] LP_IDX_ONE = (TABLE_AW)'(1);

  state_t                   r_state, w_state_nxt;
  logic [PATTERN_WIDTH-1:0] r_table [TABLE_DEPTH];
  logic [PATTERN_WIDTH-1:0] r_tdata;
  logic [TABLE_AW-1:0]      r_idx, w_idx_nxt;
  logic [TABLE_AW:0]        r_pc, w_pc_eff;
  logic [31:0]              r_frame_count, r_period, r_timer, r_frames_sent;
  logic                     r_stop_pend, r_done;
  logic                     w_hs, w_finish;

  always_comb begin
    w_pc_eff = i_pattern_count;
    if (i_pattern_count == '0)
      w_pc_eff = LP_PC_ONE;
    else if (i_pattern_count > LP_DEPTH)
      w_pc_eff = LP_DEPTH;
  end

  // A stop arriving in the handshake cycle ends the run at that handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = (r_state == ST_SEND) && i_axis_out_tready;
    w_idx_nxt   = ({1'b0, r_idx} == (r_pc - LP_PC_ONE)) ? '0 : r_idx + LP_IDX_ONE;
    w_finish    = ((r_frame_count != 32'd0) && (r_frames_sent + 32'd1 == r_frame_count))
                  || r_stop_pend || i_stop;
    case (r_state)
      ST_IDLE: if (i_start && !i_stop) w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (w_hs) begin
          if (w_finish)              w_state_nxt = ST_IDLE;
          else if (r_period <= 32'd1) w_state_nxt = ST_SEND;
          else                       w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (i_stop)                w_state_nxt = ST_IDLE;
        else if (r_timer == 32'd0) w_state_nxt = ST_SEND;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_cfg_we) r_table[i_cfg_addr] <= i_cfg_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_tdata       <= '0;
      r_idx         <= '0;
      r_pc          <= LP_PC_ONE;
      r_frame_count <= '0;
      r_period      <= '0;
      r_timer       <= '0;
      r_frames_sent <= '0;
      r_stop_pend   <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            r_frame_count <= i_frame_count;
            r_period      <= i_frame_period;
            r_pc          <= w_pc_eff;
            r_idx         <= '0;
            r_frames_sent <= '0;
            r_tdata       <= r_table[0];
            r_stop_pend   <= 1'b0;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            r_frames_sent <= r_frames_sent + 32'd1;
            r_idx         <= w_idx_nxt;
            if (w_finish) begin
              r_done      <= 1'b1;
              r_stop_pend <= 1'b0;
            end else if (r_period <= 32'd1) begin
              r_tdata <= r_table[w_idx_nxt];
            end else begin
              r_timer <= r_period - 32'd2;
            end
          end else if (i_stop) begin
            r_stop_pend <= 1'b1;
          end
        end
        ST_GAP: begin
          if (i_stop)
            r_done <= 1'b1;
          else if (r_timer == 32'd0)
            r_tdata <= r_table[r_idx];
          else
            r_timer <= r_timer - 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_axis_out_tdata  = r_tdata;
  assign o_axis_out_tvalid = (r_state == ST_SEND);
  assign o_busy            = (r_state != ST_IDLE);
  assign o_frames_sent     = r_frames_sent;
  assign o_done            = r_done;

endmodule

// File: tb/tb_simframe_sched.sv
// Scoreboard bench for simframe_sched: stimulus queues expected patterns and
// spacings; a negedge monitor checks every handshake against the queue.
module tb_simframe_sched;
  localparam int PW = 32;
  localparam int TD = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [PW-1:0] cfg_data = '0;
  logic [AW:0]   pc = '0;
  logic [31:0]   fc = '0;
  logic [31:0]   per = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [PW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          busy;
  logic [31:0]   frames;
  logic          done;

  simframe_sched #(.PATTERN_WIDTH(PW), .TABLE_DEPTH(TD), .TABLE_AW(AW)) dut (
    .i_clk(clk), .i_reset(rst), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
    .i_cfg_data(cfg_data), .i_pattern_count(pc), .i_frame_count(fc),
    .i_frame_period(per), .i_start(start), .i_stop(stop),
    .o_axis_out_tdata(tdata), .o_axis_out_tvalid(tvalid),
    .i_axis_out_tready(tready), .o_busy(busy), .o_frames_sent(frames),
    .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] tbl [TD];
  int total = 0, bad = 0, cyc = 0, last_hs = 0, hs_count = 0;

  localparam logic [31:0] PA = 32'hA0A0_0001;
  localparam logic [31:0] PB = 32'hB0B0_0002;
  localparam logic [31:0] PC_ = 32'hC0C0_0003;
  localparam logic [31:0] PD = 32'hD0D0_0004;
  localparam logic [31:0] PE = 32'hEEEE_0005;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && tvalid && tready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL hs_unexpected: got data=%h at cyc %0d, expected no handshake", tdata, cyc);
      end else begin
        e = sb.pop_front();
        if (tdata !== e.data) begin
          bad++;
          $display("FAIL hs_data: got %h, expected %h (cyc %0d)", tdata, e.data, cyc);
        end
        if (e.gap != 0) begin
          total++;
          if (cyc - last_hs != e.gap) begin
            bad++;
            $display("FAIL hs_spacing: got %0d cycles, expected %0d", cyc - last_hs, e.gap);
          end
        end
      end
      last_hs = cyc;
      hs_count++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input int g);
    exp_t e;
    e.data = d;
    e.gap  = g;
    sb.push_back(e);
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
    tick();
    cfg_we = 1'b0;
    tbl[a] = d;
  endtask

  task automatic start_run(input string name, input int p_cnt, input int f_cnt, input int period);
    pc = (AW+1)'(p_cnt); fc = f_cnt; per = period;
    hs_count = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk({name, "_start_tvalid"}, {31'd0, tvalid}, 32'd1);
    chk({name, "_start_busy"}, {31'd0, busy}, 32'd1);
    tick();
  endtask

  task automatic wait_done(input string name, input int bound, output int dcyc);
    bit seen = 0;
    dcyc = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; dcyc = cyc; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_done_timeout: got no DONE within %0d cycles, expected DONE", name, bound);
    end else begin
      chk({name, "_done_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_done_tvalid"}, {31'd0, tvalid}, 32'd0);
      @(negedge clk);
      chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    end
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcyc, vcnt;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_frames", frames, 32'd0);
    tick();

    cfg_write(0, PA); cfg_write(1, PB); cfg_write(2, PC_); cfg_write(3, PD);

    // T1: back-to-back, 5 frames over 3 entries
    tready = 1'b1;
    push(PA, 0); push(PB, 1); push(PC_, 1); push(PA, 1); push(PB, 1);
    start_run("t1", 3, 5, 0);
    wait_done("t1", 50, dcyc);
    chk("t1_done_lat", dcyc, last_hs + 1);
    chk("t1_frames", frames, 32'd5);
    chk("t1_sb_empty", sb.size(), 32'd0);

    // T2: period 10
    push(PA, 0); push(PB, 10); push(PC_, 10);
    start_run("t2", 3, 3, 10);
    wait_done("t2", 100, dcyc);
    chk("t2_done_lat", dcyc, last_hs + 1);
    chk("t2_frames", frames, 32'd3);
    chk("t2_sb_empty", sb.size(), 32'd0);

    // T3: continuous, random ready, stop while stalled
    for (int i = 0; i < 20; i++) push(tbl[i % 4], 0);
    tready = 1'b0;
    start_run("t3", 4, 0, 0);
    repeat (15) begin tready = 1'($urandom_range(0, 1)); tick(); end
    tready = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_tvalid", {31'd0, tvalid}, 32'd1);
      chk("t3_hold_tdata", tdata, tbl[hs_count % 4]);
      tick();
    end
    tready = 1'b1;
    wait_done("t3", 20, dcyc);
    chk("t3_frames", frames, hs_count);
    vcnt = 0;
    repeat (8) begin @(negedge clk); if (tvalid) vcnt++; end
    chk("t3_no_more_valid", vcnt, 32'd0);
    tick();
    sb.delete();

    // T4: stop during a long gap
    push(PA, 0);
    start_run("t4", 3, 0, 100);
    repeat (20) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_frames", frames, 32'd1);
    vcnt = 0;
    repeat (110) begin @(negedge clk); if (tvalid) vcnt++; end
    chk("t4_no_valid", vcnt, 32'd0);
    chk("t4_sb_empty", sb.size(), 32'd0);
    tick();

    // T5: overwrite the presented entry while stalled
    tready = 1'b0;
    push(PA, 0); push(PB, 1); push(PE, 1); push(PB, 1);
    start_run("t5", 2, 4, 0);
    cfg_write(0, PE);
    @(negedge clk);
    chk("t5_tdata_held", tdata, PA);
    tick();
    tready = 1'b1;
    wait_done("t5", 30, dcyc);
    chk("t5_frames", frames, 32'd4);
    chk("t5_sb_empty", sb.size(), 32'd0);
    cfg_write(0, PA);

    // T6: reset mid-run, then PATTERN_COUNT=0
    tready = 1'b1;
    for (int i = 0; i < 20; i++) push(tbl[i % 3], 0);
    start_run("t6", 3, 0, 0);
    repeat (4) tick();
    tready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_frames", frames, 32'd0);
    chk("t6_rst_tdata", tdata, 32'd0);
    tick();
    sb.delete();
    tready = 1'b1;
    push(PA, 0); push(PA, 1); push(PA, 1); push(PA, 1);
    start_run("t6b", 0, 4, 0);
    wait_done("t6b", 30, dcyc);
    chk("t6b_frames", frames, 32'd4);
    chk("t6b_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
